// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word-addressed data memory with multi-cycle access and freeze.
// Optional misaligned-access detection is compiled in with `define MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int unsigned DEPTH             = 64,
    parameter int unsigned LATENCY           = 2,
    parameter int unsigned WORD_LEN          = 32,
    parameter int unsigned REG_FILE_ADDR_LEN = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         WB_EN_IN,
    input  logic                         MEM_R_EN_IN,
    input  logic                         MEM_W_EN_IN,
    input  logic [WORD_LEN-1:0]          ALUResIn,
    input  logic [WORD_LEN-1:0]          STValIn,
    input  logic [REG_FILE_ADDR_LEN-1:0] destIn,
    output logic                         WB_EN,
    output logic                         MEM_R_EN,
    output logic [WORD_LEN-1:0]          ALURes,
    output logic [WORD_LEN-1:0]          memReadVal,
    output logic [REG_FILE_ADDR_LEN-1:0] dest,
    output logic                         freeze,
    output logic                         misalign
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [WORD_LEN-1:0] rd_val_q, rd_val_d;
    logic [WORD_LEN-1:0] mem_q [DEPTH];

    logic             req;
    logic             mis;
    logic             commit;
    logic             freeze_raw;
    logic [AddrW-1:0] idx;

    assign idx    = ALUResIn[2 +: AddrW];
    assign req    = MEM_R_EN_IN | MEM_W_EN_IN;
    assign commit = (state_q == StAccess) && (cnt_q == '0);

`ifdef MEM_ALIGN_CHECK_EN
    assign mis = (state_q == StIdle) && req && (ALUResIn[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (req && !mis) begin
                    state_d = StAccess;
                    cnt_d   = CntW'(LATENCY - 1);
                end
            end
            StAccess: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A simultaneous store wins: load data is left untouched.
    always_comb begin
        rd_val_d = rd_val_q;
        if (commit && MEM_R_EN_IN && !MEM_W_EN_IN) begin
            rd_val_d = mem_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rd_val_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_val_q <= rd_val_d;
        end
    end

    // Memory survives reset; a store caught by reset is dropped.
    always_ff @(posedge clk) begin
        if (rst && commit && MEM_W_EN_IN) begin
            mem_q[idx] <= STValIn;
        end
    end

    assign freeze_raw = ((state_q == StIdle) && req && !mis) || (state_q == StAccess);

    assign freeze     = rst & freeze_raw;
    assign misalign   = rst & mis;
    assign WB_EN      = rst & WB_EN_IN & ~freeze_raw & ~mis;
    assign MEM_R_EN   = rst & MEM_R_EN_IN & ~freeze_raw;
    assign ALURes     = ALUResIn;
    assign dest       = destIn;
    assign memReadVal = rd_val_q;

endmodule
